// File: rtl/z_branch_history_table.sv
// z_branch_history_table
//   Branch direction predictor built from 2^INDEX_BITS saturating counters.
//   With GHR_BITS=0 the table is indexed directly by PC bits (bimodal).
//   With GHR_BITS>0 the PC bits are XORed with a global history register (gshare).
//   A prediction is returned one cycle after a request. The execute stage
//   trains the table through the resolve (upd_*) port.
//
// Ports
//   clk            clock, rising edge
//   clrn           asynchronous active-low reset
//   pred_req       prediction request this cycle
//   pred_pc        PC of the branch being fetched
//   pred_valid     registered, high the cycle after pred_req
//   pred_taken     registered, MSB of the selected counter
//   pred_index     registered, index used (handed back later as upd_index)
//   upd_valid      a resolved branch is presented this cycle
//   upd_index      index captured at prediction time
//   upd_taken      actual branch outcome
//   upd_mispred    the prediction was wrong (statistics only)
//   ghr_flush      clear the global history
//   mispred_count  saturating count of mispredictions

module z_branch_history_table #(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  pred_req,
  input  logic [PC_BITS-1:0]    pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispred,
  input  logic                  ghr_flush,
  output logic [15:0]           mispred_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  // The history register is kept at least one bit wide so it stays legal
  // when GHR_BITS=0. In that case the register is never written and stays zero.
  localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0]   ctr_table [DEPTH];
  logic [GHR_W-1:0]      ghr;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [CTR_BITS-1:0]   upd_ctr_cur;
  logic [CTR_BITS-1:0]   upd_ctr_next;
  logic [CTR_BITS-1:0]   pred_ctr;
  logic                  unused_pc_bits;

  // The PC bits above the index field, and the byte offset, do not take
  // part in indexing.
  assign unused_pc_bits = ^{pred_pc[PC_BITS-1:INDEX_BITS+2], pred_pc[1:0]};

  // Build the index, compute the trained counter value, and read the
  // counter for the prediction. When an update hits the entry being
  // predicted, the post-update value is forwarded (write-first).
  // The index always uses the history as it was before this edge's shift.
  always_comb begin
    ghr_ext = '0;
    if (GHR_BITS > 0) ghr_ext = INDEX_BITS'(ghr);
    pred_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_ext;

    upd_ctr_cur  = ctr_table[upd_index];
    upd_ctr_next = upd_ctr_cur;
    if (upd_taken && (upd_ctr_cur != CTR_MAX))
      upd_ctr_next = upd_ctr_cur + 1'b1;
    else if (!upd_taken && (upd_ctr_cur != '0))
      upd_ctr_next = upd_ctr_cur - 1'b1;

    pred_ctr = ctr_table[pred_idx];
    if (upd_valid && (upd_index == pred_idx))
      pred_ctr = upd_ctr_next;
  end

  // Counter table. Reset puts every entry at weakly not-taken, and a
  // resolve writes only the entry it names.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) ctr_table[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr_table[upd_index] <= upd_ctr_next;
    end
  end

  // Global history is non-speculative: it shifts in resolved outcomes only.
  // A flush takes priority over a shift on the same edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ghr <= '0;
    end else if (ghr_flush) begin
      ghr <= '0;
    end else if (upd_valid && (GHR_BITS > 0)) begin
      ghr <= GHR_W'({ghr, upd_taken});
    end
  end

  // Prediction outputs. The taken flag and index hold when there is no
  // request, so later stages can still read the last prediction.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        pred_taken <= pred_ctr[CTR_BITS-1];
        pred_index <= pred_idx;
      end
    end
  end

  // The misprediction counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mispred_count <= '0;
    end else if (upd_valid && upd_mispred && (mispred_count != 16'hFFFF)) begin
      mispred_count <= mispred_count + 16'd1;
    end
  end

endmodule
